instruction_fetch: RTL

//   Front-end stage feeding Instruction_Decode. Owns the PC and issues word fetches to instruction

---
 rtl/instruction_fetch_pkg.sv | 23 ++
 rtl/instruction_fetch_buffer.sv | 69 ++++++
 rtl/instruction_fetch.sv | 138 +++++++++++++
 3 files changed

// File: rtl/instruction_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package instruction_fetch_pkg;

  typedef enum logic [1:0] {
    FETCH_IDLE  = 2'd0,
    FETCH_RUN   = 2'd1,
    FETCH_FLUSH = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

  localparam logic [31:0]  INSTR_NOP   = 32'h0000_0013;
  localparam logic [31:0]  WORD_BYTES  = 32'h0000_0004;
  localparam fetch_entry_t ENTRY_RESET = {INSTR_NOP, 32'h0000_0000};

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/instruction_fetch_buffer.sv
// DEPTH-entry synchronous FIFO of {instr, pc}; clear overrides push and pop.
module fetch_buffer
  import instruction_fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     clear,
  input  fetch_entry_t             wr_entry,
  output fetch_entry_t             head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ZERO  = AW'(1'b0);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1'b1);
  localparam logic [AW:0]   CNT_ZERO  = (AW+1)'(1'b0);
  localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1'b1);
  localparam logic [AW:0]   CNT_DEPTH = (AW+1)'(DEPTH);

  fetch_entry_t  mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW:0]   count_r;
  logic          push_s;
  logic          pop_s;

  // Qualify push/pop against fill level; a full buffer may still push when popping.
  always_comb begin
    push_s = push & ((count_r != CNT_DEPTH) | pop);
    pop_s  = pop & (count_r != CNT_ZERO);
  end

  // Pointer, count and storage update.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
      count_r  <= CNT_ZERO;
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= ENTRY_RESET;
      end
    end else if (clear) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
      count_r  <= CNT_ZERO;
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= wr_entry;
        wr_ptr_r        <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  assign head  = mem_r[rd_ptr_r];
  assign count = count_r;

endmodule

// File: rtl/instruction_fetch.sv
// Fetch front end: owns the PC, issues credit-limited word fetches, buffers
// responses for decode and squashes stale in-flight responses after a redirect.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int          DEPTH        = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_en,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        misalign_err
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] CNT_ZERO  = CW'(1'b0);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1'b1);
  localparam logic [CW-1:0] CNT_DEPTH = CW'(DEPTH);

  fetch_state_t  state_r;
  logic [31:0]   pc_r;
  logic [31:0]   rsp_pc_r;
  logic [CW-1:0] outstanding_r;
  logic [CW-1:0] drop_cnt_r;
  logic          misalign_err_r;

  logic [CW-1:0] count_s;
  logic [CW:0]   inflight_s;
  logic [CW-1:0] rsp_dec_s;
  logic          req_valid_s;
  logic          req_fire_s;
  logic          rsp_take_s;
  logic          push_s;
  logic          pop_s;
  fetch_entry_t  wr_entry_s;
  fetch_entry_t  head_s;

  // Request credit and handshake qualification; a redirect suppresses push, pop and request.
  always_comb begin
    inflight_s  = {1'b0, outstanding_r} + {1'b0, count_s};
    req_valid_s = (state_r == FETCH_RUN) & fetch_en & ~redirect_valid &
                  (inflight_s < {1'b0, CNT_DEPTH});
    req_fire_s  = req_valid_s & imem_req_ready;
    rsp_take_s  = imem_rsp_valid & (outstanding_r != CNT_ZERO);
    push_s      = rsp_take_s & (drop_cnt_r == CNT_ZERO) & ~redirect_valid;
    pop_s       = (count_s != CNT_ZERO) & instr_ready & ~redirect_valid;
    rsp_dec_s   = rsp_take_s ? (outstanding_r - CNT_ONE) : outstanding_r;
    wr_entry_s  = '{instr: imem_rsp_data, pc: rsp_pc_r};
  end

  fetch_buffer #(.DEPTH(DEPTH)) u_buffer (
    .clk      (clk),
    .reset    (reset),
    .push     (push_s),
    .pop      (pop_s),
    .clear    (redirect_valid),
    .wr_entry (wr_entry_s),
    .head     (head_s),
    .count    (count_s)
  );

  // Fetch control FSM together with PC, credit and drop bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r        <= FETCH_IDLE;
      pc_r           <= word_align(RESET_VECTOR);
      rsp_pc_r       <= word_align(RESET_VECTOR);
      outstanding_r  <= CNT_ZERO;
      drop_cnt_r     <= CNT_ZERO;
      misalign_err_r <= 1'b0;
    end else if (redirect_valid) begin
      // Every response still owed by memory belongs to the old path.
      pc_r           <= word_align(redirect_pc);
      rsp_pc_r       <= word_align(redirect_pc);
      outstanding_r  <= rsp_dec_s;
      drop_cnt_r     <= rsp_dec_s;
      misalign_err_r <= (redirect_pc[1:0] != 2'b00);
      if (rsp_dec_s != CNT_ZERO) begin
        state_r <= FETCH_FLUSH;
      end else if ((state_r == FETCH_IDLE) && !fetch_en) begin
        state_r <= FETCH_IDLE;
      end else begin
        state_r <= FETCH_RUN;
      end
    end else begin
      misalign_err_r <= 1'b0;
      if (req_fire_s) begin
        pc_r <= pc_r + WORD_BYTES;
      end
      if (push_s) begin
        rsp_pc_r <= rsp_pc_r + WORD_BYTES;
      end
      if (rsp_take_s && (drop_cnt_r != CNT_ZERO)) begin
        drop_cnt_r <= drop_cnt_r - CNT_ONE;
      end
      case ({req_fire_s, rsp_take_s})
        2'b10:   outstanding_r <= outstanding_r + CNT_ONE;
        2'b01:   outstanding_r <= outstanding_r - CNT_ONE;
        default: outstanding_r <= outstanding_r;
      endcase
      case (state_r)
        FETCH_IDLE:  if (fetch_en) state_r <= FETCH_RUN;
        FETCH_RUN:   state_r <= FETCH_RUN;
        FETCH_FLUSH: if ((drop_cnt_r == CNT_ZERO) ||
                         (rsp_take_s && (drop_cnt_r == CNT_ONE))) state_r <= FETCH_RUN;
        default:     state_r <= FETCH_IDLE;
      endcase
    end
  end

  // Decode-facing outputs: head of buffer, or NOP/0 when nothing is buffered.
  always_comb begin
    instr_valid = (count_s != CNT_ZERO);
    if (instr_valid) begin
      instr    = head_s.instr;
      instr_pc = head_s.pc;
    end else begin
      instr    = INSTR_NOP;
      instr_pc = 32'h0000_0000;
    end
  end

  assign imem_req_valid = req_valid_s;
  assign imem_req_addr  = pc_r;
  assign misalign_err   = misalign_err_r;

endmodule
